// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared constants, types and helpers for the audio serial transmit path.
//
// Contents:
//   FRAME_BITS / SLOT_BITS / DATA_BITS : I2S frame geometry (64 / 32 / 16)
//   CNT_W / SLOT_W / DATA_W            : bit widths derived from the geometry
//   frame_src_e                        : where the frame register is loaded from
//   slot_bit()                         : picks the serial bit for a slot index
// ---------------------------------------------------------------------------
package audio_pkg;

  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;
  localparam int DATA_BITS  = 16;

  localparam int CNT_W  = $clog2(FRAME_BITS);
  localparam int SLOT_W = $clog2(SLOT_BITS);
  localparam int DATA_W = $clog2(DATA_BITS);

  // Source selected for the frame register at the start of every frame.
  typedef enum logic [1:0] {
    SRC_HOLD   = 2'd0,
    SRC_BYPASS = 2'd1,
    SRC_ZERO   = 2'd2
  } frame_src_e;

  // Returns the bit to put on sdata for slot index k (0..63) of a frame
  // whose left word sits in [31:16] and right word in [15:0]. The top bit
  // of k selects the channel, the low bits pick the position within the
  // 32-bit slot. Positions past the 16 data bits are zero padding.
  // The word bit to send at position p is 15-p, which is just ~p in 4 bits,
  // so the frame index is {channel_is_left, ~p[3:0]}.
  function automatic logic slot_bit(input logic [2*DATA_BITS-1:0] frame,
                                    input logic [CNT_W-1:0]       k);
    logic [SLOT_W-1:0] p;
    logic [DATA_W:0]   idx;
    logic              bit_out;
    p   = k[SLOT_W-1:0];
    idx = {~k[CNT_W-1], ~p[DATA_W-1:0]};
    if (p < SLOT_W'(DATA_BITS)) begin
      bit_out = frame[idx];
    end else begin
      bit_out = 1'b0;
    end
    return bit_out;
  endfunction

endpackage

// File: rtl/i2s_tx_bclk_gen.sv
// ---------------------------------------------------------------------------
// bclk_gen
// Bit-clock divider for the I2S transmitter. A counter runs 0..CLK_DIV-1
// and bclk toggles at terminal count, so one bclk half-period lasts CLK_DIV
// clk cycles. The strobes are high on the clk cycle whose rising edge
// makes bclk fall / rise, letting the parent update its serial outputs on
// exactly that edge.
//
// Parameters:
//   CLK_DIV          clk cycles per bclk half-period (legal 2..1024)
// Ports:
//   clk              bus clock
//   rst              synchronous, active-high reset (bclk low, counter 0)
//   bclk             I2S bit clock
//   bclk_fall_strobe high on the cycle whose edge drives bclk 1 -> 0
//   bclk_rise_strobe high on the cycle whose edge drives bclk 0 -> 1
// ---------------------------------------------------------------------------
module bclk_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  output logic bclk,
  output logic bclk_fall_strobe,
  output logic bclk_rise_strobe
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic             terminal;

  assign terminal = (div_cnt == DIV_W'(CLK_DIV - 1));

  // Free-running divider. The counter wraps at terminal count and bclk
  // flips on the same edge, so after reset the first rise comes CLK_DIV
  // cycles later and the first fall 2*CLK_DIV cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (terminal) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Strobes are gated by rst so nothing downstream advances while the
  // block is held in reset.
  assign bclk_fall_strobe = terminal &  bclk & ~rst;
  assign bclk_rise_strobe = terminal & ~bclk & ~rst;

endmodule

// File: rtl/i2s_tx.sv
// ---------------------------------------------------------------------------
// i2s_tx
// I2S transmitter: takes one 32-bit stereo sample per frame (left in
// [31:16], right in [15:0], signed 16-bit each) and serialises it MSB first
// with the standard one-bit delay after each lrclk transition. Each 32-bit
// slot carries 16 data bits followed by 16 zero padding bits.
//
// A one-entry holding register decouples the upstream producer from the
// frame timing. At every frame start the frame register is loaded from the
// holding register, or straight from sample_i if a sample arrives on that
// very cycle, or with zero (flagged as an underrun) if nothing is there.
//
// Optional feature (macro I2S_TX_UNDERRUN_CNT_EN): adds a 16-bit saturating
// underrun counter output, underrun_cnt. Without the macro the port and the
// counter do not exist; the underrun pulse is always present.
//
// Parameters:
//   CLK_DIV      clk cycles per bclk half-period (legal 2..1024)
// Ports:
//   clk          100 MHz bus clock
//   rst          synchronous, active-high reset
//   en           sample_i valid this cycle
//   ready        holding register empty, a sample can be accepted
//   sample_i     stereo sample, [31:16] left, [15:0] right
//   bclk         I2S bit clock
//   lrclk        word select, 0 = left, 1 = right
//   sdata        serial data, MSB first
//   frame_start  one-clk pulse when a frame is loaded
//   underrun     one-clk pulse when a frame loads with no sample available
//   underrun_cnt saturating underrun count (only with I2S_TX_UNDERRUN_CNT_EN)
// ---------------------------------------------------------------------------
module i2s_tx
  import audio_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   ready,
  input  logic [2*DATA_BITS-1:0] sample_i,
  output logic                   bclk,
  output logic                   lrclk,
  output logic                   sdata,
  output logic                   frame_start,
  output logic                   underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]            underrun_cnt
`endif
);

  logic                   bclk_fall;
  logic                   bclk_rise;

  logic [CNT_W-1:0]       bit_cnt;
  logic [CNT_W-1:0]       bit_cnt_next;
  logic [2*DATA_BITS-1:0] hold_reg;
  logic                   hold_full;
  logic [2*DATA_BITS-1:0] frame_reg;

  logic                   frame_load;
  frame_src_e             frame_src;
  logic [2*DATA_BITS-1:0] frame_data_next;
  logic                   accept;
  logic                   hold_full_next;

  bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk_gen (
    .clk              (clk),
    .rst              (rst),
    .bclk             (bclk),
    .bclk_fall_strobe (bclk_fall),
    .bclk_rise_strobe (bclk_rise)
  );

  // The rise strobe is part of the divider's interface but every serial
  // output here changes on the falling edge only.
  logic unused_rise;
  assign unused_rise = bclk_rise;

  // The frame bit counter holds the index of the last falling edge. It
  // resets to the last index so that the first falling edge after reset
  // is edge 0 and loads a new frame.
  assign bit_cnt_next = bit_cnt + CNT_W'(1);
  assign frame_load   = bclk_fall && (bit_cnt == CNT_W'(FRAME_BITS - 1));

  // Decide where the next frame comes from and how the holding register
  // changes this cycle. A sample offered on the load cycle while the
  // holding register is empty goes straight into the frame register and
  // is not also captured, otherwise it would be sent twice.
  always_comb begin
    frame_src       = SRC_ZERO;
    frame_data_next = '0;
    accept          = 1'b0;
    hold_full_next  = hold_full;

    if (hold_full) begin
      frame_src       = SRC_HOLD;
      frame_data_next = hold_reg;
    end else if (en) begin
      frame_src       = SRC_BYPASS;
      frame_data_next = sample_i;
    end

    accept = en && ready && !(frame_load && (frame_src == SRC_BYPASS));

    if (frame_load && hold_full) begin
      hold_full_next = 1'b0;
    end
    if (accept) begin
      hold_full_next = 1'b1;
    end
  end

  // Holding register and its registered ready flag. ready mirrors the
  // next-state emptiness so it drops right after an accept and rises right
  // after a frame load drains the register. It stays low during reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
      ready     <= 1'b0;
    end else begin
      hold_full <= hold_full_next;
      ready     <= ~hold_full_next;
      if (accept) begin
        hold_reg <= sample_i;
      end
    end
  end

  // Frame timing and serialiser. On falling edge n the new counter value
  // is n, lrclk follows its top bit, and sdata carries slot bit n-1 which
  // is the old counter value. That gives the one-bit I2S delay for free:
  // edge 0 sends the last padding bit of the previous right slot while the
  // new frame is being loaded, and edge 1 sends the new left MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= CNT_W'(FRAME_BITS - 1);
      frame_reg   <= '0;
      lrclk       <= 1'b0;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= frame_load;
      underrun    <= frame_load && (frame_src == SRC_ZERO);
      if (bclk_fall) begin
        bit_cnt <= bit_cnt_next;
        lrclk   <= bit_cnt_next[CNT_W-1];
        sdata   <= slot_bit(frame_reg, bit_cnt);
      end
      if (frame_load) begin
        frame_reg <= frame_data_next;
      end
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  // Saturating underrun counter; it sticks at all-ones rather than
  // wrapping so a long-running fault never reads back as a small number.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (frame_load && (frame_src == SRC_ZERO) &&
                 (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx
// Self-checking bench for i2s_tx with CLK_DIV = 2 (one frame = 256 clk).
// The stimulus process pushes the frame it expects the DUT to transmit
// into a queue; a monitor process rebuilds each transmitted frame from the
// bclk falling edges and compares it against the queue head.
// Build with +define+I2S_TX_UNDERRUN_CNT_EN to also check underrun_cnt.
// ---------------------------------------------------------------------------
module tb_i2s_tx;

  localparam int CLK_DIV = 2;

  typedef struct packed {
    logic [31:0] data;
    logic        urun;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic        ready;
  logic [31:0] sample_i;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        frame_start;
  logic        underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  exp_t exp_q[$];
  int   check_count;
  int   pass_count;
  int   exp_ucnt;

  i2s_tx #(
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .ready        (ready),
    .sample_i     (sample_i),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .frame_start  (frame_start),
    .underrun     (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the whole run is a few thousand cycles.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Offer one sample for one clk (inputs change at negedge).
  task automatic applyStimulus(input logic [31:0] s);
    en       = 1'b1;
    sample_i = s;
    @(negedge clk);
    en       = 1'b0;
  endtask

  task automatic pushFrame(input logic [31:0] data, input logic urun);
    exp_t e;
    e.data = data;
    e.urun = urun;
    exp_q.push_back(e);
    if (urun) exp_ucnt++;
  endtask

  // Advance until the next frame_start sample; reports whether ready stayed
  // low on every sample before it.
  task automatic waitFrame(output logic ready_low_all);
    logic seen;
    seen          = 1'b0;
    ready_low_all = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frame_start) begin
        seen = 1'b1;
        break;
      end
      if (ready !== 1'b0) ready_low_all = 1'b0;
    end
    checkOutput("frame_start_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_bclk"},        {31'd0, bclk},        32'd0);
    checkOutput({tag, "_lrclk"},       {31'd0, lrclk},       32'd0);
    checkOutput({tag, "_sdata"},       {31'd0, sdata},       32'd0);
    checkOutput({tag, "_frame_start"}, {31'd0, frame_start}, 32'd0);
    checkOutput({tag, "_underrun"},    {31'd0, underrun},    32'd0);
    checkOutput({tag, "_ready"},       {31'd0, ready},       32'd0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    checkOutput({tag, "_underrun_cnt"}, {16'd0, underrun_cnt}, 32'd0);
`endif
  endtask

  // Release reset and check ready and first-frame latency (2*CLK_DIV).
  // The first frame finds the holding register empty, so it is an underrun.
  task automatic releaseReset();
    int fs_at;
    rst   = 1'b0;
    fs_at = -1;
    pushFrame(32'h0, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) checkOutput("ready_after_release", {31'd0, ready}, 32'd1);
      if (frame_start) begin
        fs_at = i;
        break;
      end
    end
    checkOutput("first_frame_latency", 32'(fs_at), 32'(2 * CLK_DIV));
  endtask

  // Monitor: rebuilds each frame from bclk falling edges. Edge m (0 at
  // frame_start) carries slot bit m-1: left data on 1..16, right data on
  // 33..48, padding elsewhere; lrclk is 1 from edge 32 on.
  initial begin
    int          m;
    logic        prev_bclk;
    logic        active;
    logic        after_fs;
    logic        lr_ok;
    logic        pad_ok;
    logic        fs_ok;
    logic        urun_seen;
    logic [31:0] got;
    logic [4:0]  idx;
    exp_t        e;
    m         = 0;
    prev_bclk = 1'b0;
    active    = 1'b0;
    after_fs  = 1'b0;
    lr_ok     = 1'b1;
    pad_ok    = 1'b1;
    fs_ok     = 1'b1;
    urun_seen = 1'b0;
    got       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active   = 1'b0;
        after_fs = 1'b0;
      end else begin
        if (after_fs) begin
          if (frame_start || underrun) fs_ok = 1'b0;
          after_fs = 1'b0;
        end
        if (prev_bclk && !bclk) begin
          if (frame_start) begin
            m         = 0;
            active    = 1'b1;
            got       = '0;
            lr_ok     = 1'b1;
            pad_ok    = 1'b1;
            fs_ok     = 1'b1;
            urun_seen = underrun;
            after_fs  = 1'b1;
          end else if (active) begin
            m++;
          end
          if (active) begin
            if (lrclk !== ((m >= 32) ? 1'b1 : 1'b0)) lr_ok = 1'b0;
            if (m >= 1 && m <= 16) begin
              idx      = 5'(32 - m);
              got[idx] = sdata;
            end else if (m >= 33 && m <= 48) begin
              idx      = 5'(48 - m);
              got[idx] = sdata;
            end else if (sdata !== 1'b0) begin
              pad_ok = 1'b0;
            end
            if (m == 48) begin
              checkOutput("expected_frame_queued", 32'(exp_q.size() != 0), 32'd1);
              if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("frame_data",        got,               e.data);
                checkOutput("frame_underrun",    {31'd0, urun_seen}, {31'd0, e.urun});
                checkOutput("frame_lrclk",       {31'd0, lr_ok},     32'd1);
                checkOutput("frame_padding",     {31'd0, pad_ok},    32'd1);
                checkOutput("frame_pulse_width", {31'd0, fs_ok},     32'd1);
              end
            end
          end
        end
      end
      prev_bclk = bclk;
    end
  end

  // Stimulus: directed scenarios, each pushing its expected frame before
  // the frame load that should carry it.
  initial begin
    logic rl;
    check_count = 0;
    pass_count  = 0;
    exp_ucnt    = 0;
    rst         = 1'b1;
    en          = 1'b0;
    sample_i    = '0;

    // Reset held for 5 clk, then release (frame F1 = underrun).
    repeat (5) @(negedge clk);
    checkResetOutputs("reset");
    releaseReset();

    // Data framing: sample accepted during F1, sent in F2.
    pushFrame(32'hA5A5_3C3C, 1'b0);
    applyStimulus(32'hA5A5_3C3C);
    checkOutput("ready_drop_after_accept", {31'd0, ready}, 32'd0);
    waitFrame(rl);
    checkOutput("ready_after_load", {31'd0, ready}, 32'd1);

    // Underrun: three frames with no sample.
    pushFrame(32'h0, 1'b1);
    pushFrame(32'h0, 1'b1);
    pushFrame(32'h0, 1'b1);
    waitFrame(rl);
    waitFrame(rl);
    waitFrame(rl);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    checkOutput("underrun_cnt_after_gap", {16'd0, underrun_cnt}, 32'(exp_ucnt));
`endif

    // Back-pressure: second sample on the next cycle is dropped.
    pushFrame(32'h1111_2222, 1'b0);
    applyStimulus(32'h1111_2222);
    applyStimulus(32'h3333_4444);
    checkOutput("ready_low_backpressure", {31'd0, ready}, 32'd0);
    waitFrame(rl);
    checkOutput("ready_low_until_load", {31'd0, rl}, 32'd1);
    checkOutput("ready_after_bp_load", {31'd0, ready}, 32'd1);

    // Bypass: sample offered exactly on the load cycle of the next frame.
    pushFrame(32'h7FFF_8000, 1'b0);
    repeat (255) @(negedge clk);
    applyStimulus(32'h7FFF_8000);
    checkOutput("bypass_load_aligned", {31'd0, frame_start}, 32'd1);
    checkOutput("bypass_ready_kept", {31'd0, ready}, 32'd1);

    // Reset mid-frame at bit 20 of an underrun frame.
    pushFrame(32'h0, 1'b1);
    waitFrame(rl);
    repeat (20 * 2 * CLK_DIV) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    exp_ucnt = 0;
    @(negedge clk);
    checkResetOutputs("midframe_reset");
    repeat (2) @(negedge clk);
    releaseReset();

    // Boundary sample values after the mid-frame reset.
    pushFrame(32'h8001_7FFE, 1'b0);
    applyStimulus(32'h8001_7FFE);
    waitFrame(rl);
    pushFrame(32'h0, 1'b1);
    waitFrame(rl);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    checkOutput("underrun_cnt_after_reset", {16'd0, underrun_cnt}, 32'(exp_ucnt));
`endif
    repeat (200) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
